// File: rtl/de1_board_io_if.sv
// Avalon-MM slave bus between the HPS bridge and the DE1-SoC board I/O block.
interface de1_board_io_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/de1_board_io.sv
// DE1-SoC board I/O: debounced switches/keys with press-edge IRQ, HPS-driven LEDR and
// seven-segment digits behind a small Avalon-MM register file.
module de1_seg_digit (
    input  logic [3:0] nibble,
    input  logic       enable,
    input  logic       lamp,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        if (lamp) begin
            seg = 7'h00;
        end else if (enable) begin
            case (nibble)
                4'h0: seg = 7'h40;
                4'h1: seg = 7'h79;
                4'h2: seg = 7'h24;
                4'h3: seg = 7'h30;
                4'h4: seg = 7'h19;
                4'h5: seg = 7'h12;
                4'h6: seg = 7'h02;
                4'h7: seg = 7'h78;
                4'h8: seg = 7'h00;
                4'h9: seg = 7'h10;
                4'hA: seg = 7'h08;
                4'hB: seg = 7'h03;
                4'hC: seg = 7'h46;
                4'hD: seg = 7'h21;
                4'hE: seg = 7'h06;
                default: seg = 7'h0E;
            endcase
        end
    end
endmodule

module de1_board_io #(
    parameter int N_SW            = 10,
    parameter int N_KEY           = 4,
    parameter int N_LED           = 10,
    parameter int N_HEX           = 6,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_SW-1:0]    sw_in,
    input  logic [N_KEY-1:0]   key_in,
    output logic [7*N_HEX-1:0] hex_out,
    output logic [N_LED-1:0]   ledr_out,
    de1_board_io_if.slave      bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [CW-1:0]    tick_cnt;
    logic             tick;
    logic [N_SW-1:0]  sw_s1, sw_s2, sw_samp, sw_db, sw_stable;
    logic [N_KEY-1:0] key_s1, key_s2, key_samp, key_db, key_stable, key_db_nxt, key_press;
    logic [N_KEY-1:0] key_edge, irq_mask, w1c;
    logic [N_LED-1:0] led;
    logic [4*N_HEX-1:0] hex_val;
    logic [N_HEX-1:0] hex_en;
    logic             lamp;
    logic             wr_en, rd_en;
    logic [31:0]      rd_mux;
    logic [N_HEX-1:0][6:0] seg_nxt;
    logic             unused_wd;

    assign tick = (tick_cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tick_cnt <= '0;
        else          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    // Per bit: accept the synced level only if it matched the previous tick's sample.
    assign sw_stable  = ~(sw_s2 ^ sw_samp);
    assign key_stable = ~(key_s2 ^ key_samp);
    assign key_db_nxt = (~key_s2 & key_stable) | (key_db & ~key_stable);
    assign key_press  = tick ? (key_db_nxt & ~key_db) : '0;

    // Key sync/sample flops hold the raw active-low level, so they reset to released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            sw_samp  <= '0;
            sw_db    <= '0;
            key_s1   <= '1;
            key_s2   <= '1;
            key_samp <= '1;
            key_db   <= '0;
        end else begin
            sw_s1  <= sw_in;
            sw_s2  <= sw_s1;
            key_s1 <= key_in;
            key_s2 <= key_s1;
            if (tick) begin
                sw_samp  <= sw_s2;
                key_samp <= key_s2;
                sw_db    <= (sw_s2 & sw_stable) | (sw_db & ~sw_stable);
                key_db   <= key_db_nxt;
            end
        end
    end

    assign wr_en     = bus.chipselect & bus.write;
    assign rd_en     = bus.chipselect & bus.read;
    assign w1c       = (wr_en && bus.address == 3'd2) ? bus.writedata[N_KEY-1:0] : '0;
    assign unused_wd = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_edge <= '0;
            irq_mask <= '0;
            led      <= '0;
            hex_val  <= '0;
            hex_en   <= '0;
            lamp     <= 1'b0;
        end else begin
            // A press landing on the same edge as its W1C survives.
            key_edge <= (key_edge & ~w1c) | key_press;
            if (wr_en) begin
                case (bus.address)
                    3'd3: irq_mask <= bus.writedata[N_KEY-1:0];
                    3'd4: led      <= bus.writedata[N_LED-1:0];
                    3'd5: hex_val  <= bus.writedata[4*N_HEX-1:0];
                    3'd6: begin
                        hex_en <= bus.writedata[N_HEX-1:0];
                        lamp   <= bus.writedata[8];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            3'd0: rd_mux[N_SW-1:0]    = sw_db;
            3'd1: rd_mux[N_KEY-1:0]   = key_db;
            3'd2: rd_mux[N_KEY-1:0]   = key_edge;
            3'd3: rd_mux[N_KEY-1:0]   = irq_mask;
            3'd4: rd_mux[N_LED-1:0]   = led;
            3'd5: rd_mux[4*N_HEX-1:0] = hex_val;
            3'd6: begin
                rd_mux[N_HEX-1:0] = hex_en;
                rd_mux[8]         = lamp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   bus.readdata <= '0;
        else if (rd_en) bus.readdata <= rd_mux;
    end

    assign bus.irq  = |(key_edge & irq_mask);
    assign ledr_out = led;

    for (genvar d = 0; d < N_HEX; d++) begin : g_dig
        de1_seg_digit u_dig (
            .nibble (hex_val[4*d +: 4]),
            .enable (hex_en[d]),
            .lamp   (lamp),
            .seg    (seg_nxt[d])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hex_out <= '1;
        else          hex_out <= seg_nxt;
    end
endmodule

// File: tb/tb_de1_board_io.sv
// Scoreboarded bench for de1_board_io with a fast debounce tick and a register-level model.
module tb_de1_board_io;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  sw_in = '0;
    logic [3:0]  key_in = '1;
    logic [41:0] hex_out;
    logic [9:0]  ledr_out;
    de1_board_io_if bus();

    de1_board_io #(.N_SW(10), .N_KEY(4), .N_LED(10), .N_HEX(6), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .sw_in(sw_in), .key_in(key_in),
        .hex_out(hex_out), .ledr_out(ledr_out), .bus(bus)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic        rd_d;

    // Model of the architectural state.
    logic [9:0]  m_sw;
    logic [3:0]  m_key, m_edge, m_mask;
    logic [9:0]  m_led;
    logic [23:0] m_hexv;
    logic [5:0]  m_hexen;
    logic        m_lamp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sw = '0; m_key = '0; m_edge = '0; m_mask = '0;
        m_led = '0; m_hexv = '0; m_hexen = '0; m_lamp = 1'b0;
    endtask

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r[9:0]  = m_sw;
            3'd1: r[3:0]  = m_key;
            3'd2: r[3:0]  = m_edge;
            3'd3: r[3:0]  = m_mask;
            3'd4: r[9:0]  = m_led;
            3'd5: r[23:0] = m_hexv;
            3'd6: begin r[5:0] = m_hexen; r[8] = m_lamp; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic apply_write(input logic [2:0] a, input logic [31:0] d);
        case (a)
            3'd2: m_edge = m_edge & ~d[3:0];
            3'd3: m_mask = d[3:0];
            3'd4: m_led  = d[9:0];
            3'd5: m_hexv = d[23:0];
            3'd6: begin m_hexen = d[5:0]; m_lamp = d[8]; end
            default: ;
        endcase
    endtask

    function automatic logic [41:0] exp_hex();
        logic [41:0] h;
        for (int d = 0; d < 6; d++)
            h[7*d +: 7] = m_lamp ? 7'h00 : (m_hexen[d] ? SEG[m_hexv[4*d +: 4]] : 7'h7F);
        return h;
    endfunction

    task automatic bus_op(input bit rd, input bit wr, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.read = rd; bus.write = wr;
        bus.address = a; bus.writedata = d;
        if (rd) exp_q.push_back(exp_read(a));
        if (wr) apply_write(a, d);
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_hex"}, hex_out, exp_hex());
        chk({tag, "_ledr"}, ledr_out, m_led);
        chk({tag, "_irq"}, bus.irq, |(m_edge & m_mask));
    endtask

    task automatic sw_hold(input logic [9:0] v, input int n);
        sw_in = v;
        repeat (n) @(negedge clk);
        m_sw = v;
    endtask

    task automatic key_hold(input logic [3:0] pressed, input int n);
        key_in = ~pressed;
        repeat (n) @(negedge clk);
        m_edge = m_edge | (pressed & ~m_key);
        m_key  = pressed;
    endtask

    // Monitor: readdata is due one cycle after each accepted read.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_d <= 1'b0;
        else          rd_d <= bus.chipselect & bus.read;
    end

    always @(negedge clk) begin
        if (reset_n && rd_d) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL read_unexpected: got %0h expected none", bus.readdata);
            end else begin
                chk("readdata", bus.readdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        int irq_hits;
        logic [2:0]  a;
        logic [31:0] d;
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.address = '0; bus.writedata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_hex", hex_out, {42{1'b1}});
        chk("rst_ledr", ledr_out, 10'h0);
        chk("rst_irq", bus.irq, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) bus_op(1, 0, 3'(i), 0);

        sw_hold(10'h2A5, 20);
        bus_op(1, 0, 3'd0, 0);

        // Alternate every 4 cycles so no two consecutive ticks see the same level.
        for (int i = 0; i < 10; i++) begin
            sw_in = (i % 2 == 0) ? 10'h15A : 10'h2A5;
            repeat (4) @(negedge clk);
        end
        sw_in = 10'h2A5;
        bus_op(1, 0, 3'd0, 0);

        bus_op(0, 1, 3'd3, 32'h4);
        key_hold(4'b0100, 20);
        bus_op(1, 0, 3'd1, 0);
        bus_op(1, 0, 3'd2, 0);
        check_outputs("press2");
        chk("press2_irq_hi", bus.irq, 1'b1);
        bus_op(0, 1, 3'd2, 32'h4);
        chk("w1c_irq_lo", bus.irq, 1'b0);
        key_hold(4'b0000, 20);
        bus_op(1, 0, 3'd2, 0);

        bus_op(0, 1, 3'd5, 32'h00C0FFEE);
        bus_op(0, 1, 3'd6, 32'h3F);
        check_outputs("hex_coffee");
        chk("hex_coffee_const", hex_out, {7'h46, 7'h40, 7'h0E, 7'h0E, 7'h06, 7'h06});
        bus_op(0, 1, 3'd6, 32'h100);
        check_outputs("lamp");
        bus_op(0, 1, 3'd6, 32'h0);
        check_outputs("blank");
        bus_op(1, 0, 3'd7, 0);

        // Continuous W1C while key1 gets pressed: the set must win once.
        bus_op(0, 1, 3'd3, 32'h2);
        key_in = ~4'b0010;
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 3'd2; bus.writedata = 32'h2;
        irq_hits = 0;
        repeat (24) begin
            @(negedge clk);
            if (bus.irq) irq_hits++;
        end
        bus.chipselect = 1'b0; bus.write = 1'b0;
        chk("w1c_vs_set_irq_pulses", irq_hits, 1);
        m_key = 4'b0010;
        bus_op(1, 0, 3'd2, 0);
        bus_op(1, 0, 3'd1, 0);
        key_hold(4'b0000, 20);

        for (int i = 0; i < 24; i++) begin
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            case ($urandom_range(0, 3))
                0: bus_op(0, 1, a, d);
                1: bus_op(1, 1, a, d);
                2: sw_hold(10'($urandom), 20);
                default: key_hold(4'($urandom), 20);
            endcase
            bus_op(1, 0, 3'($urandom_range(0, 7)), 0);
            check_outputs("rand");
        end

        // Reset in the middle of a debounce with an IRQ pending and outputs driven.
        bus_op(0, 1, 3'd3, 32'h8);
        bus_op(0, 1, 3'd4, 32'h3FF);
        bus_op(0, 1, 3'd6, 32'h13F);
        sw_hold(10'h3C3, 20);
        key_hold(4'b1000, 20);
        bus_op(1, 0, 3'd0, 0);
        check_outputs("pre_rst");
        key_in = ~4'b0001;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_ledr", ledr_out, 10'h0);
        chk("async_rst_hex", hex_out, {42{1'b1}});
        chk("async_rst_irq", bus.irq, 1'b0);
        chk("async_rst_rdata", bus.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        sw_in = '0;
        key_hold(4'b0001, 20);
        bus_op(1, 0, 3'd1, 0);
        bus_op(1, 0, 3'd2, 0);
        bus_op(0, 1, 3'd2, 32'h1);
        key_hold(4'b0001, 20);
        bus_op(1, 0, 3'd2, 0);
        check_outputs("post_rst");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
